// File: rtl/link_anim_sequencer_pkg.sv
// Shared types and keycode values for the player sprite animation logic.
package link_anim_pkg;

  typedef enum logic [1:0] {DOWN = 2'd0, UP = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

  typedef enum logic [2:0] {
    WALK1  = 3'd0,
    WALK2  = 3'd1,
    SWORD1 = 3'd2,
    SWORD2 = 3'd3,
    SWORD3 = 3'd4,
    SWORD4 = 3'd5
  } frame_t;

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, ATTACK = 2'd2} state_t;

  localparam logic [7:0] DEF_KEY_W   = 8'h1A;
  localparam logic [7:0] DEF_KEY_S   = 8'h16;
  localparam logic [7:0] DEF_KEY_A   = 8'h04;
  localparam logic [7:0] DEF_KEY_D   = 8'h07;
  localparam logic [7:0] DEF_KEY_ATK = 8'h2C;

endpackage

// File: rtl/link_anim_sequencer_vs_edge_tick.sv
// Falling-edge detector on active-low vertical sync; one registered pulse per video frame.
module vs_edge_tick (
  input  logic Clk,
  input  logic Reset,
  input  logic vs,
  output logic frame_tick
);

  logic vs_prev;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_prev    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_prev    <= vs;
      frame_tick <= vs_prev & ~vs;
    end
  end

endmodule

// File: rtl/link_anim_sequencer.sv
// Player sprite animation controller: picks facing and frame (idle, walk cycle, sword attack)
// from the keycode, stepping frames on video-frame ticks.
module link_anim_sequencer
  import link_anim_pkg::*;
#(
  parameter int         WALK_DIV  = 8,
  parameter int         SWORD_DIV = 4,
  parameter logic [7:0] KEY_W     = DEF_KEY_W,
  parameter logic [7:0] KEY_S     = DEF_KEY_S,
  parameter logic [7:0] KEY_A     = DEF_KEY_A,
  parameter logic [7:0] KEY_D     = DEF_KEY_D,
  parameter logic [7:0] KEY_ATK   = DEF_KEY_ATK
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  output logic [4:0] sprite_sel,
  output logic [1:0] facing,
  output logic       attacking,
  output logic       wide_palette,
  output logic       frame_tick
);

  localparam int MAX_DIV = (WALK_DIV > SWORD_DIV) ? WALK_DIV : SWORD_DIV;
  localparam int CW      = $clog2(MAX_DIV) + 1;
  localparam logic [CW-1:0] WALK_LAST  = CW'(WALK_DIV - 1);
  localparam logic [CW-1:0] SWORD_LAST = CW'(SWORD_DIV - 1);

  state_t        state, state_n;
  dir_t          facing_r, facing_n;
  frame_t        frame_r, frame_n;
  logic [CW-1:0] count, count_n;
  logic [7:0]    keycode_prev;
  logic          dir_valid, atk_edge;
  dir_t          dir;

  vs_edge_tick u_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .vs         (vs),
    .frame_tick (frame_tick)
  );

  always_comb begin
    dir_valid = 1'b0;
    dir       = DOWN;
    case (keycode)
      KEY_W:   begin dir_valid = 1'b1; dir = UP;    end
      KEY_S:   begin dir_valid = 1'b1; dir = DOWN;  end
      KEY_A:   begin dir_valid = 1'b1; dir = LEFT;  end
      KEY_D:   begin dir_valid = 1'b1; dir = RIGHT; end
      default: ;
    endcase
    atk_edge = (keycode == KEY_ATK) && (keycode_prev != KEY_ATK);
  end

  // Every state change clears the counter, so a tick landing on that cycle is dropped.
  always_comb begin
    state_n  = state;
    facing_n = facing_r;
    frame_n  = frame_r;
    count_n  = count;
    case (state)
      IDLE: begin
        frame_n = WALK1;
        count_n = '0;
        if (atk_edge) begin
          state_n = ATTACK;
          frame_n = SWORD1;
        end else if (dir_valid) begin
          state_n  = WALK;
          facing_n = dir;
        end
      end
      WALK: begin
        if (atk_edge) begin
          state_n = ATTACK;
          frame_n = SWORD1;
          count_n = '0;
        end else if (!dir_valid) begin
          state_n = IDLE;
          frame_n = WALK1;
          count_n = '0;
        end else begin
          facing_n = dir;
          if (frame_tick) begin
            if (count == WALK_LAST) begin
              count_n = '0;
              frame_n = (frame_r == WALK1) ? WALK2 : WALK1;
            end else begin
              count_n = count + 1'b1;
            end
          end
        end
      end
      ATTACK: begin
        if (frame_tick) begin
          if (count == SWORD_LAST) begin
            count_n = '0;
            if (frame_r == SWORD4) begin
              frame_n = WALK1;
              if (dir_valid) begin
                state_n  = WALK;
                facing_n = dir;
              end else begin
                state_n = IDLE;
              end
            end else begin
              frame_n = frame_t'(frame_r + 3'd1);
            end
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        frame_n = WALK1;
        count_n = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      facing_r     <= DOWN;
      frame_r      <= WALK1;
      count        <= '0;
      keycode_prev <= 8'h00;
      sprite_sel   <= 5'd0;
      attacking    <= 1'b0;
      wide_palette <= 1'b1;
    end else begin
      state        <= state_n;
      facing_r     <= facing_n;
      frame_r      <= frame_n;
      count        <= count_n;
      keycode_prev <= keycode;
      sprite_sel   <= {facing_n, frame_n};
      attacking    <= (state_n == ATTACK);
      wide_palette <= (frame_n == WALK1) && ((facing_n == DOWN) || (facing_n == UP));
    end
  end

  assign facing = facing_r;

endmodule

// File: doc/link_anim_sequencer.md
Name: link_anim_sequencer

Overview:
- Per-frame animation controller for the player sprite.
- Takes the keyboard keycode and VGA vertical sync, and decides which sprite frame, and therefore which frame ROM and palette, the colour mapper uses.
- Sequences idle, walk-cycle and four-phase sword-attack frames per facing direction.
- Sits between the USB keycode register and the sprite ROM/palette mux in the colour mapper.

Parameters:
- WALK_DIV, 8: number of video frames each walk frame is held (≥1).
- SWORD_DIV, 4: number of video frames each sword phase is held (≥1).
- KEY_W, 8'h1A / KEY_S, 8'h16 / KEY_A, 8'h04 / KEY_D, 8'h07: up/down/left/right keycodes.
- KEY_ATK, 8'h2C: attack keycode (space).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- vs  in  1  VGA vertical sync, active-low.
- keycode  in  8  current USB keycode; 0 = no key.
- sprite_sel  out  5  {facing[1:0], frame[2:0]}; registered.
- facing  out  2  0=down, 1=up, 2=left, 3=right.
- attacking  out  1  high while in ATTACK.
- wide_palette  out  1  high when the selected frame uses a 16-entry palette (4-bit index). This is frame 0 with facing down or up.
- frame_tick  out  1  one-Clk pulse per video frame (exported for sprite motion logic).

Behaviour:
- Frame codes: 0=walk1 (also idle), 1=walk2, 2..5=sword phase 1..4. Codes 6 and 7 are never produced.
- Tick: vs_prev is registered. frame_tick=1 for exactly one Clk on the cycle after vs_prev=1, vs=0 is sampled (falling edge). vs_prev resets to 1.
- Key decode: dir_key is valid only for the four direction keycodes. Any other keycode is "none". atk_edge = (keycode==KEY_ATK) && (keycode_prev!=KEY_ATK). keycode_prev resets to 0.
- Reset values (all outputs/registers): state IDLE, facing 0, frame 0, sprite_sel 0, attacking 0, wide_palette 1, frame_tick 0, counter 0.
- Latency: all outputs update on the Clk edge after the causing input is sampled. There is no combinational path from input to output.
- States:
  - IDLE: frame=0, counter=0.
    - dir_key valid → facing←dir, state WALK, frame 0, counter 0.
    - atk_edge → ATTACK, frame 2, counter 0.
    - atk_edge has priority over dir_key (mutually exclusive since keycode is a single byte).
  - WALK:
    - dir_key valid → facing←dir every cycle. A direction change does NOT reset counter or frame.
    - On frame_tick: if counter==WALK_DIV-1, then counter←0 and frame toggles 0↔1; else counter++.
    - No dir_key → IDLE, frame 0, counter 0.
    - atk_edge → ATTACK, frame 2, counter 0.
  - ATTACK:
    - Keycode ignored; facing frozen.
    - On frame_tick: if counter==SWORD_DIV-1, then counter←0 and frame advances 2→3→4→5.
    - Counter wrap at frame 5: if dir_key valid → WALK, facing←dir, frame 0; else → IDLE, frame 0. attacking drops the same cycle.
    - Holding space through the end does not retrigger; a release and re-press is required.
- Counter: width $clog2(max(WALK_DIV,SWORD_DIV))+1. Counter advances only on frame_tick.
- Simultaneous events:
  - frame_tick arriving on the cycle the state changes is consumed by the new state's reset of counter, i.e. it is not counted.
  - Reset wins over everything, including mid-attack, and returns to the reset values.
- wide_palette = (frame==0) && (facing==0 || facing==1). It is registered alongside sprite_sel.

Decomposition:
- Package link_anim_pkg contains:
  - dir_t enum (DOWN, UP, LEFT, RIGHT).
  - frame_t enum (WALK1, WALK2, SWORD1..SWORD4).
  - state_t enum (IDLE, WALK, ATTACK).
  - Keycode localparams.
- Sub-module vs_edge_tick: vs falling-edge detector producing frame_tick. It is reused by the enemy animation logic.

Test Plan:
- Reset held 2 cycles, keycode=0, vs toggling → sprite_sel=5'b00000, wide_palette=1, attacking=0, no state change for 100 ticks.
- keycode=8'h07 (D), WALK_DIV=8 → facing=3 next Clk. sprite_sel alternates 5'b11000 / 5'b11001, changing every 8 frame_ticks. keycode=0 → 5'b11000 and IDLE next Clk.
- Idle facing down, keycode=8'h2C pulse → attacking=1. sprite_sel 5'b00010, 00011, 00100, 00101, each held 4 ticks. Then 5'b00000 with attacking=0 after tick 16.
- Attack with keycode switched to 8'h04 at phase 2 → facing stays 0 through phase 4. At end, state WALK, facing=2, sprite_sel=5'b10000.
- Space held continuously across an attack end → IDLE, no second attack. Release then re-press → new attack starts.
- Reset asserted during sword phase 3 facing right → next Clk sprite_sel=0, facing=0, attacking=0. vs low held for 3 Clk → exactly one frame_tick.
